// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding and
// the two's-complement overflow rule used by the final stage.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Overflow when both addend MSBs agree and the sum MSB disagrees with them.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice; one instance per pipeline stage.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] i_A,
  input  logic [CW-1:0] i_B,
  input  logic          i_cin,
  output logic [CW-1:0] o_S,
  output logic          o_cout
);

  logic [CW:0] w_sum;

  assign w_sum = {1'b0, i_A} + {1'b0, i_B} + {{CW{1'b0}}, i_cin};
  assign {o_cout, o_S} = w_sum;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk per stage, carry
// registered between stages, valid/ready handshake with a global advance enable.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_cin,
  input  logic             i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_S,
  output logic             o_Cout,
  output logic             o_ovf
);

  localparam int CW = WIDTH / STAGES;

  // Each A register shifts right by CW per stage while the produced sum chunk
  // enters at the top, so after the last stage it holds the complete result.
  logic [WIDTH-1:0]  r_as [STAGES];
  logic [WIDTH-1:0]  r_b  [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_op;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [CW-1:0]     w_sum   [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_op_in;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_cout;
  logic              w_en;
  logic              w_ovf;

  assign w_en = !r_v[STAGES-1] || i_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // SUB is A + ~B + ~borrow; inversion happens once at entry.
      assign w_a_in[k]  = i_A;
      assign w_b_in[k]  = (i_op == OP_SUB) ? ~i_B : i_B;
      assign w_c_in[k]  = i_cin ^ (i_op == OP_SUB);
      assign w_op_in[k] = i_op;
      assign w_v_in[k]  = i_valid;
    end else begin : g_next
      assign w_a_in[k]  = r_as[k-1];
      assign w_b_in[k]  = r_b[k-1];
      assign w_c_in[k]  = r_c[k-1];
      assign w_op_in[k] = r_op[k-1];
      assign w_v_in[k]  = r_v[k-1];
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .i_A    (w_a_in[k][CW-1:0]),
      .i_B    (w_b_in[k][CW-1:0]),
      .i_cin  (w_c_in[k]),
      .o_S    (w_sum[k]),
      .o_cout (w_cout[k])
    );
  end

  assign w_ovf = ovf_detect(w_a_in[STAGES-1][CW-1], w_b_in[STAGES-1][CW-1],
                            w_sum[STAGES-1][CW-1]);

  // Valid chain: cleared by reset, shifts only when the pipe advances.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v <= {STAGES{1'b0}};
    end else if (w_en) begin
      r_v <= w_v_in;
    end
  end

  // Datapath registers: no reset, advance with the global enable.
  always_ff @(posedge i_clk) begin
    if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_as[k] <= (w_a_in[k] >> CW) | (WIDTH'(w_sum[k]) << (WIDTH - CW));
        r_b[k]  <= w_b_in[k] >> CW;
        r_c[k]  <= w_cout[k];
        r_op[k] <= w_op_in[k];
      end
      r_ovf <= w_ovf;
    end
  end

  assign o_ready = w_en;
  assign o_valid = r_v[STAGES-1];
  assign o_S     = r_as[STAGES-1];
  // For SUB the final carry is inverted to give the borrow.
  assign o_Cout  = r_c[STAGES-1] ^ (r_op[STAGES-1] == OP_SUB);
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=32, STAGES=4) with an arithmetic
// reference model and a scoreboard comparing every consumed result.
module tb_adder_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, o_ready, i_cin, i_op, o_valid, i_ready, o_Cout, o_ovf;
  logic [31:0] i_A, i_B, o_S;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_A(i_A), .i_B(i_B), .i_cin(i_cin), .i_op(i_op),
    .o_valid(o_valid), .i_ready(i_ready), .o_S(o_S), .o_Cout(o_Cout), .o_ovf(o_ovf)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] b; logic cin; logic op;} vec_t;
  typedef struct packed {logic cout; logic ovf; logic [31:0] s;} res_t;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   sidx   = 0;
  res_t exp_q[$];
  vec_t stim[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic op);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.op = op;
    return v;
  endfunction

  function automatic res_t mkr(input logic cout, input logic ovf, input logic [31:0] s);
    res_t r;
    r.cout = cout; r.ovf = ovf; r.s = s;
    return r;
  endfunction

  // Reference: exact integer arithmetic, unsigned for carry/borrow, signed for overflow.
  function automatic res_t model(input vec_t v);
    longint u, sv;
    res_t   r;
    if (v.op == 1'b0) begin
      u  = longint'(v.a) + longint'(v.b) + longint'(v.cin);
      sv = longint'($signed(v.a)) + longint'($signed(v.b)) + longint'(v.cin);
      r.cout = (u > 64'sd4294967295);
    end else begin
      u  = longint'(v.a) - longint'(v.b) - longint'(v.cin);
      sv = longint'($signed(v.a)) - longint'($signed(v.b)) - longint'(v.cin);
      r.cout = (u < 64'sd0);
    end
    r.s   = u[31:0];
    r.ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: handshake rule, stall stability, in-order result compare.
  initial begin
    logic  prev_stall;
    res_t  prev_out;
    res_t  r;
    vec_t  cur;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (i_rst === 1'b1) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        check("ready_rule", 64'(o_ready), 64'(!o_valid || i_ready));
        if (prev_stall && o_valid)
          check("stall_hold", 64'({o_Cout, o_ovf, o_S}), 64'(prev_out));
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 64'(exp_q.size()), 64'd1);
          end else begin
            r = exp_q.pop_front();
            check("result", 64'({o_Cout, o_ovf, o_S}), 64'(r));
            pops++;
          end
        end
        prev_stall = o_valid && !i_ready;
        prev_out   = {o_Cout, o_ovf, o_S};
        if (i_valid && o_ready) begin
          cur = mk(i_A, i_B, i_cin, i_op);
          exp_q.push_back(model(cur));
        end
      end
    end
  end

  // Drives stim[] for ncyc cycles; bit t of rdy/rst is i_ready/i_rst in cycle t.
  task automatic run(input int ncyc, input logic [63:0] rdy, input logic [63:0] rst,
                     output logic [63:0] vpat, output logic [63:0] rpat, output res_t first);
    logic got;
    vpat = 64'd0; rpat = 64'd0; first = '0; got = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      i_rst   = rst[t];
      i_ready = rdy[t];
      if (!rst[t] && sidx < stim.size()) begin
        i_A = stim[sidx].a; i_B = stim[sidx].b;
        i_cin = stim[sidx].cin; i_op = stim[sidx].op;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      vpat[t] = o_valid;
      rpat[t] = o_ready;
      if (o_valid && !got) begin
        first = {o_Cout, o_ovf, o_S};
        got   = 1'b1;
      end
      if (!i_rst && i_valid && o_ready) sidx++;
    end
    i_valid = 1'b0;
  endtask

  vec_t        dv [6];
  res_t        dx [6];
  logic [63:0] vp, rp;
  res_t        fo;
  int          pre;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_A = 32'd0; i_B = 32'd0; i_cin = 1'b0; i_op = 1'b0;

    dv[0] = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); dx[0] = mkr(1'b1, 1'b0, 32'h0000_0000);
    dv[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); dx[1] = mkr(1'b0, 1'b1, 32'h8000_0000);
    dv[2] = mk(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0); dx[2] = mkr(1'b0, 1'b0, 32'h0000_0004);
    dv[3] = mk(32'd5,         32'd7,         1'b0, 1'b1); dx[3] = mkr(1'b1, 1'b0, 32'hFFFF_FFFE);
    dv[4] = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1); dx[4] = mkr(1'b0, 1'b1, 32'h7FFF_FFFF);
    dv[5] = mk(32'd10,        32'd3,         1'b1, 1'b1); dx[5] = mkr(1'b0, 1'b0, 32'h0000_0006);

    for (int i = 0; i < 6; i++) check("model_pin", 64'(model(dv[i])), 64'(dx[i]));

    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_ready", 64'(o_ready), 64'd1);

    // Single transactions: latency 4 and hand-computed results.
    for (int i = 0; i < 6; i++) begin
      stim.push_back(dv[i]);
      run(6, {64{1'b1}}, 64'd0, vp, rp, fo);
      check("latency", vp, 64'h10);
      check("directed", 64'(fo), 64'(dx[i]));
    end

    // Eight back-to-back mixed ADD/SUB with carries crossing chunk edges.
    stim.push_back(mk(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0));
    stim.push_back(mk(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1));
    stim.push_back(mk(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1));
    stim.push_back(mk(32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 1'b0));
    stim.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0));
    stim.push_back(mk(32'h0001_0000, 32'h0000_FFFF, 1'b1, 1'b1));
    stim.push_back(mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0));
    stim.push_back(mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1));
    pre = pops;
    run(14, {64{1'b1}}, 64'd0, vp, rp, fo);
    check("stream_valid", vp, 64'h0FF0);
    check("stream_count", 64'(pops - pre), 64'd8);

    // Backpressure: i_ready low in cycles 5..7 with the pipe full.
    for (int i = 0; i < 8; i++)
      stim.push_back(mk(32'h0100_0000 * i + 32'h00FF_FFF0, 32'h0000_0011 * i, i[0], i[1]));
    pre = pops;
    run(18, 64'hFFFF_FFFF_FFFF_FF1F, 64'd0, vp, rp, fo);
    check("bp_valid", vp, 64'h7FF0);
    check("bp_ready", 64'(rp[17:0]), 64'h3FF1F);
    check("bp_count", 64'(pops - pre), 64'd8);
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset in cycle 3 with three in flight; new transaction in cycle 4.
    stim.push_back(mk(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0));
    stim.push_back(mk(32'h3333_3333, 32'h1111_1111, 1'b0, 1'b1));
    stim.push_back(mk(32'h4444_4444, 32'h4444_4444, 1'b1, 1'b0));
    stim.push_back(mk(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1));
    pre = pops;
    run(12, {64{1'b1}}, 64'h8, vp, rp, fo);
    check("rst_valid", vp, 64'h100);
    check("rst_ready_after", 64'(rp[4]), 64'd1);
    check("rst_count", 64'(pops - pre), 64'd1);
    check("rst_result", 64'(fo), 64'(mkr(1'b0, 1'b0, 32'h0000_00FF)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined two-operand adder/subtractor with a valid/ready stream handshake. It generalises the team's 32-bit combinational adder: operand width and pipeline depth are parameters, and it adds a carry-in, a subtract mode, carry/borrow and signed-overflow outputs, and backpressure. It sits between operand producers and result consumers in the datapath where a full-width single-cycle carry chain does not close timing.

## Interface

- `WIDTH`, default 32: operand and result width in bits; must be ≥ 2.
- `STAGES`, default 4: number of pipeline stages; WIDTH % STAGES == 0; chunk width CW = WIDTH/STAGES.

- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: reset; **synchronous, active-high**.
- `i_valid`, in, 1: input operands valid.
- `o_ready`, out, 1: block can accept input this cycle.
- `i_A`, in, WIDTH: operand A.
- `i_B`, in, WIDTH: operand B.
- `i_cin`, in, 1: carry-in for ADD; borrow-in for SUB.
- `i_op`, in, 1: 0 = ADD, 1 = SUB.
- `o_valid`, out, 1: result valid.
- `i_ready`, in, 1: downstream accepts result.
- `o_S`, out, WIDTH: result.
- `o_Cout`, out, 1: ADD gives the carry-out. SUB gives the borrow-out (1 when the unsigned A < B + borrow-in).
- `o_ovf`, out, 1: two's-complement signed overflow.

## Operation

- ADD: {o_Cout, o_S} = A + B + cin.
- SUB: internally A + ~B + ~cin. The result is o_S = A − B − cin. o_Cout is the inverted final carry, so it acts as the borrow.
- o_ovf: true when the operand MSBs match and the result MSB differs. For SUB, "operands" here means A and the inverted B.
- Stage k (0..STAGES−1) adds chunk k, bits [k·CW +: CW], using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Operand chunks not yet consumed are delay-registered alongside their transaction.
- Result chunks already produced are delay-registered alongside their transaction.
- The op bit travels with its transaction, so mixed ADD/SUB streams are exact.
- Global advance enable: en = !o_valid || i_ready; o_ready = en.
- When en = 0, every stage register holds, including valid bits.
- Per-stage valid bits shift with en.
- Bubbles are not compressed; an invalid stage still advances when en = 1.
- Input is accepted when i_valid && o_ready. Output is consumed when o_valid && i_ready.
- Data registers are not reset; only valid bits are.

## Timing

- Reset values: o_valid = 0, all internal valid bits = 0, o_ready = 1.
- o_S, o_Cout and o_ovf are don't-care while o_valid = 0. The bench must not check them then.
- Latency: a transaction accepted at edge n appears with o_valid = 1 after edge n+STAGES, assuming no stall.
- Throughput: 1 transaction/cycle while i_ready = 1.
- Stall: if o_valid && !i_ready, outputs hold stable and o_ready = 0 in the same cycle. Upstream data is not captured.
- Simultaneous pop and push in one cycle (full pipe, i_ready = 1): legal, no loss.
- Reset asserted mid-stream drops all in-flight transactions. On the cycle after reset deasserts: o_valid = 0, o_ready = 1.
- o_ready depends combinationally on i_ready. There is no combinational path from i_A/i_B to o_S.
- STAGES = 1 degenerates to a single registered full-width adder with latency 1.

## Structure

- Package `adder_pkg`:
  - op encoding constants `OP_ADD` = 1'b0 and `OP_SUB` = 1'b1.
  - a helper function for signed-overflow detection.
- Sub-module `adder_chunk`: a combinational CW-bit adder slice with ports (A, B, cin, S, cout). Instantiate it once per stage with a generate loop.
- The top level holds the triangular skew/de-skew register arrays, valid chain and enable logic.

## Test plan

All scenarios use WIDTH = 32, STAGES = 4.

- **Reset.** After reset: o_valid = 0, o_ready = 1. Then ADD 0xFFFFFFFF + 0x00000001, cin = 0, accepted at edge n → at n+4: o_S = 0x00000000, o_Cout = 1, o_ovf = 0.
- **Signed overflow.** ADD 0x7FFFFFFF + 0x00000001 → o_S = 0x80000000, o_Cout = 0, o_ovf = 1. ADD 0x00000001 + 0x00000002 with cin = 1 → o_S = 0x00000004.
- **Subtract.**
  - SUB 5 − 7, cin = 0 → o_S = 0xFFFFFFFE, o_Cout = 1, o_ovf = 0.
  - SUB 0x80000000 − 1 → o_S = 0x7FFFFFFF, o_ovf = 1.
  - SUB 10 − 3 with cin = 1 → o_S = 6, o_Cout = 0.
- **Streaming.** Stream 8 back-to-back mixed ADD/SUB transactions with i_ready = 1 → 8 results on consecutive cycles, in order, matching the reference model. The first result appears 4 cycles after the first accept.
- **Backpressure.** Hold i_ready = 0 for 3 cycles while the pipe is full. Expect o_ready = 0, o_S stable, no transaction lost or duplicated. Then raise i_ready → results resume in order.
- **Reset mid-stream.** Assert i_rst with 3 transactions in flight → the cycle after release o_valid = 0. None of the 3 ever appear. A new transaction is accepted immediately.
